// File: rtl/wishbone_burst_master.sv
// ---------------------------------------------------------------------------
// wishbone_burst_master
//
// Purpose: issues a burst of 1..2^LEN_W-1 single-beat Wishbone classic
// transfers. Each beat is one ACTIVE phase (cyc+stb held until ack)
// followed by a one-cycle GAP (stb low, cyc high) or, after the last beat,
// a one-cycle DONE pulse. The burst is launched from IDLE by i_begin.
//
// Optional feature: define WB_TIMEOUT_EN to add a per-beat ack timeout
// (TIMEOUT_CYCLES ACTIVE cycles). On expiry the burst is aborted, o_error
// is set and DONE is still entered. Without the macro no counter exists
// and o_error is tied to 0.
//
// Handshake: a Wishbone beat completes on the rising edge where stb (our
// output) and i_wb_ack are both high. An ack while stb is low is ignored.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_begin              start request (sampled in IDLE only)
//   i_writeEnable        1 = write burst, 0 = read burst
//   i_address            start address
//   i_length             beat count (0 treated as 1)
//   i_writeData          write word (with i_begin, then in each GAP)
//   o_dataReq            GAP cycle of a write burst: next word wanted
//   o_readData           last captured read word
//   o_readValid          one-cycle pulse, o_readData just updated
//   o_busy               not IDLE
//   o_done               one-cycle completion pulse (DONE state)
//   o_error              timeout flag, cleared by the next accepted start
//   o_state              current state (IDLE=0 ACTIVE=1 GAP=2 DONE=3)
//   o_wb_cyc/stb/we/adr/dat, i_wb_dat, i_wb_ack   Wishbone master side
// ---------------------------------------------------------------------------
module wishbone_burst_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int LEN_W          = 4,
  parameter int ADDR_INC       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_begin,
  input  logic              i_writeEnable,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LEN_W-1:0]  i_length,
  input  logic [DATA_W-1:0] i_writeData,
  output logic              o_dataReq,
  output logic [DATA_W-1:0] o_readData,
  output logic              o_readValid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [1:0]        o_state,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic [DATA_W-1:0] o_wb_dat,
  input  logic [DATA_W-1:0] i_wb_dat,
  input  logic              i_wb_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic              we_q;
  // Beats still to transfer, including the one currently in flight.
  logic [LEN_W-1:0]  beats_q;
  logic [DATA_W-1:0] read_data_q;
  logic              read_valid_q;

  logic              beat_ack;
  logic              last_beat;
  logic              timeout;

  // Ack only counts while stb is high, i.e. in ACTIVE.
  assign beat_ack  = (state == S_ACTIVE) && i_wb_ack;
  assign last_beat = (beats_q == LEN_W'(1));

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Number of ACTIVE cycles of the current beat already spent without ack.
  logic [CNT_W-1:0] wait_cnt;
  logic             error_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
    end else if ((state == S_ACTIVE) && !i_wb_ack) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th ACTIVE cycle of a beat with no ack.
  assign timeout = (state == S_ACTIVE) && !i_wb_ack && (wait_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      error_q <= 1'b0;
    end else if ((state == S_IDLE) && i_begin) begin
      error_q <= 1'b0;
    end else if (timeout) begin
      error_q <= 1'b1;
    end
  end

  assign o_error = error_q;
`else
  assign timeout = 1'b0;
  assign o_error = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_begin) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (beat_ack) begin
          state_nxt = last_beat ? S_DONE : S_GAP;
        end else if (timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_GAP:   state_nxt = S_ACTIVE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Burst context and read capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      beats_q      <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_begin) begin
            adr_q   <= i_address;
            dat_q   <= i_writeData;
            we_q    <= i_writeEnable;
            beats_q <= (i_length == '0) ? LEN_W'(1) : i_length;
          end
        end
        S_ACTIVE: begin
          if (i_wb_ack) begin
            if (!we_q) begin
              read_data_q  <= i_wb_dat;
              read_valid_q <= 1'b1;
            end
            beats_q <= beats_q - LEN_W'(1);
            // Address wraps naturally at 2^ADDR_W.
            if ((ADDR_INC != 0) && !last_beat) begin
              adr_q <= adr_q + ADDR_W'(1);
            end
          end
        end
        S_GAP: begin
          if (we_q) dat_q <= i_writeData;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs are decoded from the state so reset clears them immediately.
  assign o_wb_cyc    = (state == S_ACTIVE) || (state == S_GAP);
  assign o_wb_stb    = (state == S_ACTIVE);
  assign o_wb_we     = o_wb_cyc && we_q;
  assign o_wb_adr    = adr_q;
  assign o_wb_dat    = dat_q;
  assign o_dataReq   = (state == S_GAP) && we_q;
  assign o_readData  = read_data_q;
  assign o_readValid = read_valid_q;
  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);
  assign o_state     = state;

endmodule

// File: tb/tb_wishbone_burst_master.sv
// ---------------------------------------------------------------------------
// tb_wishbone_burst_master
//
// Directed and randomized bursts against a behavioural slave/reference:
// each beat's expected address is start+beat (mod 256) for the
// incrementing instance and start for the fixed-address instance, write
// words must appear on the bus in the order supplied, read words are
// queued by the slave and must come back in order on o_readValid.
// ---------------------------------------------------------------------------
module tb_wishbone_burst_master;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 4;

  // Clock / reset
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  // DUT inputs
  logic          i_begin;
  logic          i_writeEnable;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_length;
  logic [DW-1:0] i_writeData;
  logic [DW-1:0] i_wb_dat;
  logic          i_wb_ack;

  // Incrementing-address instance outputs
  logic          o_dataReq, o_readValid, o_busy, o_done, o_error;
  logic [DW-1:0] o_readData, o_wb_dat;
  logic [1:0]    o_state;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_adr;

  // Fixed-address instance outputs
  logic          f_dataReq, f_readValid, f_busy, f_done, f_error;
  logic [DW-1:0] f_readData, f_wb_dat;
  logic [1:0]    f_state;
  logic          f_wb_cyc, f_wb_stb, f_wb_we;
  logic [AW-1:0] f_wb_adr;

  wishbone_burst_master #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ADDR_INC(1), .TIMEOUT_CYCLES(255)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_begin(i_begin),
    .i_writeEnable(i_writeEnable), .i_address(i_address), .i_length(i_length),
    .i_writeData(i_writeData), .o_dataReq(o_dataReq), .o_readData(o_readData),
    .o_readValid(o_readValid), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_state(o_state), .o_wb_cyc(o_wb_cyc),
    .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
    .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack)
  );

  wishbone_burst_master #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ADDR_INC(0), .TIMEOUT_CYCLES(255)
  ) dut_fix (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_begin(i_begin),
    .i_writeEnable(i_writeEnable), .i_address(i_address), .i_length(i_length),
    .i_writeData(i_writeData), .o_dataReq(f_dataReq), .o_readData(f_readData),
    .o_readValid(f_readValid), .o_busy(f_busy), .o_done(f_done),
    .o_error(f_error), .o_state(f_state), .o_wb_cyc(f_wb_cyc),
    .o_wb_stb(f_wb_stb), .o_wb_we(f_wb_we), .o_wb_adr(f_wb_adr),
    .o_wb_dat(f_wb_dat), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack)
  );

  // Scoreboard
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one burst and act as a Wishbone slave until o_done.
  //   pattern >= 0 : write word i = pattern*(i+1), read data = pattern
  //   hammer       : keep i_begin high with junk while busy (must be ignored)
  task automatic run_burst(input bit we_in, input int addr, input int len,
                           input int wait_lo, input int wait_hi,
                           input int pattern, input bit hammer);
    int n, beat, cyc_cnt, waitc, dreq, rv;
    bit done_seen;
    logic [DW-1:0] wd[16];
    logic [DW-1:0] r;
    logic [DW-1:0] e;
    n = (len == 0) ? 1 : len;
    for (int i = 0; i < 16; i++) wd[i] = (pattern >= 0) ? DW'(pattern * (i + 1)) : DW'($urandom);

    i_begin = 1'b1; i_writeEnable = we_in; i_address = AW'(addr);
    i_length = LW'(len); i_writeData = wd[0];
    @(posedge i_clk); #1;
    i_begin = hammer;
    chk("busy_after_begin", o_busy, 1);
    chk("state_active_after_begin", o_state, 1);
    chk("error_cleared_on_begin", o_error, 0);

    beat = 0; cyc_cnt = 1; dreq = 0; rv = 0; done_seen = 0;
    waitc = $urandom_range(wait_hi, wait_lo);
    while (cyc_cnt < 400 && !done_seen) begin
      i_wb_ack = 1'b0;
      i_writeData = DW'($urandom);
      if (hammer) begin
        i_writeEnable = 1'($urandom); i_address = AW'($urandom); i_length = LW'($urandom);
      end
      if (o_readValid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("read_data", o_readData, e);
        rv++;
      end
      if (o_done) begin
        done_seen = 1;
        chk("fixed_done_aligned", f_done, 1);
        chk("cyc_low_in_done", o_wb_cyc, 0);
      end else if (o_wb_stb) begin
        chk("beat_adr", o_wb_adr, (addr + beat) & 32'hFF);
        chk("fixed_beat_adr", f_wb_adr, addr & 32'hFF);
        chk("beat_we", o_wb_we, we_in);
        if (we_in) chk("beat_wdata", o_wb_dat, wd[beat]);
        if (waitc == 0) begin
          i_wb_ack = 1'b1;
          r = (pattern >= 0) ? DW'(pattern) : DW'($urandom);
          i_wb_dat = r;
          if (!we_in) exp_q.push_back(r);
          beat++;
          waitc = $urandom_range(wait_hi, wait_lo);
        end else begin
          waitc--;
        end
      end else begin
        chk("cyc_high_in_gap", o_wb_cyc, 1);
        chk("state_gap", o_state, 2);
        // Stray ack while stb is low must not complete a beat.
        i_wb_ack = 1'($urandom);
        i_wb_dat = DW'($urandom);
        if (o_dataReq) begin
          dreq++;
          i_writeData = wd[beat];
        end
      end
      if (!done_seen) begin
        @(posedge i_clk); #1;
        cyc_cnt++;
      end
    end
    i_begin = 1'b0;
    i_wb_ack = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("beat_count", beat, n);
    chk("read_valid_count", rv, we_in ? 0 : n);
    chk("data_req_count", dreq, we_in ? n - 1 : 0);
    chk("read_queue_empty", exp_q.size(), 0);
    if (wait_hi == 0) chk("burst_cycles", cyc_cnt, 2 * n);
    @(posedge i_clk); #1;
    chk("done_one_cycle", o_done, 0);
    chk("idle_after_done", o_state, 0);
    chk("busy_low_after_done", o_busy, 0);
    chk("cyc_low_after_done", o_wb_cyc, 0);
    chk("error_low_after_burst", o_error, 0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt;
    i_begin = 0; i_writeEnable = 0; i_address = '0; i_length = '0;
    i_writeData = '0; i_wb_dat = '0; i_wb_ack = 0;

    // Reset state
    repeat (2) @(posedge i_clk); #1;
    chk("rst_state", o_state, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_adr", o_wb_adr, 0);
    chk("rst_read_valid", o_readValid, 0);
    i_rst_n = 1'b1;

    // Single read, ack after 3 wait cycles returning 0xA5
    run_burst(1'b0, 'h0B, 1, 3, 3, 'hA5, 1'b0);
    chk("single_read_data", o_readData, 8'hA5);
    // Write burst 0x40.. with 0x11/0x22/0x33, zero-wait
    run_burst(1'b1, 'h40, 3, 0, 0, 'h11, 1'b0);
    // Address wrap 0xFF -> 0x00
    run_burst(1'b1, 'hFF, 2, 0, 0, -1, 1'b0);
    run_burst(1'b0, 'hFF, 2, 0, 0, -1, 1'b0);
    // Length 0 with i_begin held high while busy
    run_burst(1'b0, 'h33, 0, 0, 2, -1, 1'b1);
    run_burst(1'b1, 'h34, 0, 0, 0, -1, 1'b1);
    // Randomized bursts
    for (int k = 0; k < 24; k++) begin
      run_burst(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                0, int'($urandom_range(0, 3)), -1, 1'($urandom));
    end

    // Reset mid-burst: 4-beat read, reset during beat 2
    i_begin = 1'b1; i_writeEnable = 1'b0; i_address = 8'h20; i_length = 4'd4;
    @(posedge i_clk); #1;
    i_begin = 1'b0; i_wb_ack = 1'b1; i_wb_dat = 8'h5A;
    @(posedge i_clk); #1;
    i_wb_ack = 1'b0;
    chk("midrst_gap", o_state, 2);
    chk("midrst_captured", o_readData, 8'h5A);
    @(posedge i_clk); #1;
    chk("midrst_beat2_stb", o_wb_stb, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_cyc", o_wb_cyc, 0);
    chk("midrst_stb", o_wb_stb, 0);
    chk("midrst_state", o_state, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_read_data", o_readData, 0);
    chk("midrst_adr", o_wb_adr, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      chk("midrst_no_done", o_done, 0);
    end
    // Release and start on the first rising edge
    i_rst_n = 1'b1;
    i_begin = 1'b1; i_writeEnable = 1'b0; i_address = 8'h77; i_length = 4'd1;
    @(posedge i_clk); #1;
    i_begin = 1'b0;
    chk("post_rst_accept", o_state, 1);
    chk("post_rst_adr", o_wb_adr, 8'h77);
    i_wb_ack = 1'b1; i_wb_dat = 8'hC3;
    @(posedge i_clk); #1;
    i_wb_ack = 1'b0;
    chk("post_rst_done", o_done, 1);
    chk("post_rst_rdata", o_readData, 8'hC3);
    chk("post_rst_rvalid", o_readValid, 1);
    @(posedge i_clk); #1;

`ifdef WB_TIMEOUT_EN
    // Ack never arrives: stb must stay up exactly 255 cycles
    i_begin = 1'b1; i_writeEnable = 1'b0; i_address = 8'h10; i_length = 4'd3;
    @(posedge i_clk); #1;
    i_begin = 1'b0;
    cnt = 0;
    while (o_wb_stb && cnt < 300) begin
      cnt++;
      @(posedge i_clk); #1;
    end
    chk("timeout_stb_cycles", cnt, 255);
    chk("timeout_done", o_done, 1);
    chk("timeout_error", o_error, 1);
    chk("timeout_cyc_low", o_wb_cyc, 0);
    @(posedge i_clk); #1;
    chk("timeout_idle", o_state, 0);
    chk("timeout_error_held", o_error, 1);
    // Next accepted start clears the flag (checked inside run_burst)
    run_burst(1'b1, 'h10, 1, 0, 0, -1, 1'b0);
`else
    cnt = 0;
    chk("no_timeout_error_tied", o_error | f_error, cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
